btn_channel_ctrl: RTL and testbench

Sequences the measurement-channel selection for the 13-channel voltmeter from debounced push-button events. The block consumes `db_level`/`db_tick` pairs from three upstream button debouncers (UP, DOWN, HOME) and adds press-and-hold auto-repeat. It arbitrates simultaneous requests and defers each channel change until the ADC sequencer is idle. Its `ch_sel` output drives the ADC channel mux and the display channel readout.

---
 rtl/voltmeter_pkg.sv | 23 ++
 rtl/btn_repeat.sv | 75 +++++++
 rtl/btn_channel_ctrl.sv | 96 +++++++++
 tb/tb_btn_channel_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/voltmeter_pkg.sv
// Shared types and constants for the voltmeter front-panel logic.
// Covers command encoding, button bit positions and the hold/repeat FSM states.
package voltmeter_pkg;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_INC,
    CMD_DEC,
    CMD_ZERO
  } cmd_t;

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_HOLD,
    RPT_RUN
  } rpt_state_t;

  localparam int BTN_UP      = 0;
  localparam int BTN_DOWN    = 1;
  localparam int BTN_HOME    = 2;
  localparam int NCH_DEFAULT = 13;

endpackage

// File: rtl/btn_repeat.sv
// Press-and-hold auto-repeat for one debounced button.
// Emits a step on the press tick, again after HOLD_CYC cycles, then every REPEAT_CYC cycles.
module btn_repeat #(
  parameter int HOLD_CYC   = 50_000_000,
  parameter int REPEAT_CYC = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic level,
  input  logic tick,
  output logic step
);
  import voltmeter_pkg::*;

  // Counter sized for the longer hold interval; the repeat interval must fit in it too.
  localparam int CW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] RPT_LAST  = CW'(REPEAT_CYC - 1);

  rpt_state_t state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= RPT_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    step       = 1'b0;
    case (state_reg)
      RPT_IDLE: begin
        if (tick) begin
          step       = 1'b1;
          state_next = RPT_HOLD;
          cnt_next   = '0;
        end
      end
      RPT_HOLD: begin
        if (!level) begin
          state_next = RPT_IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == HOLD_LAST) begin
          step       = 1'b1;
          state_next = RPT_RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RPT_RUN: begin
        if (!level) begin
          state_next = RPT_IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == RPT_LAST) begin
          step     = 1'b1;
          cnt_next = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = RPT_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: rtl/btn_channel_ctrl.sv
// Channel selection for the voltmeter: button arbitration, a one-deep command register
// held off while the ADC is busy, and the wrapping channel register.
module btn_channel_ctrl #(
  parameter int NCH        = voltmeter_pkg::NCH_DEFAULT,
  parameter int HOLD_CYC   = 50_000_000,
  parameter int REPEAT_CYC = 10_000_000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2:0]             db_level,
  input  logic [2:0]             db_tick,
  input  logic                   adc_busy,
  output logic [$clog2(NCH)-1:0] ch_sel,
  output logic                   ch_update,
  output logic                   pending
);
  import voltmeter_pkg::*;

  localparam int CHW = $clog2(NCH);
  localparam logic [CHW-1:0] CH_LAST = CHW'(NCH - 1);

  logic [1:0]     step;
  logic           home_evt;
  cmd_t           cmd_new;
  cmd_t           cmd_reg;
  logic           pending_reg;
  logic           update_reg;
  logic [CHW-1:0] ch_sel_reg, ch_sel_next;

  // UP and DOWN share the same hold/repeat behaviour; index matches BTN_UP/BTN_DOWN.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rpt
      btn_repeat #(
        .HOLD_CYC  (HOLD_CYC),
        .REPEAT_CYC(REPEAT_CYC)
      ) u_rpt (
        .clk  (clk),
        .reset(reset),
        .level(db_level[gi]),
        .tick (db_tick[gi]),
        .step (step[gi])
      );
    end
  endgenerate

  assign home_evt = db_tick[BTN_HOME] & db_level[BTN_HOME];

  // HOME dominates; simultaneous UP and DOWN cancel out.
  always_comb begin
    cmd_new = CMD_NONE;
    if (home_evt)
      cmd_new = CMD_ZERO;
    else if (step[BTN_UP] && !step[BTN_DOWN])
      cmd_new = CMD_INC;
    else if (step[BTN_DOWN] && !step[BTN_UP])
      cmd_new = CMD_DEC;
  end

  always_comb begin
    ch_sel_next = ch_sel_reg;
    case (cmd_reg)
      CMD_INC:  ch_sel_next = (ch_sel_reg == CH_LAST) ? '0 : ch_sel_reg + 1'b1;
      CMD_DEC:  ch_sel_next = (ch_sel_reg == '0) ? CH_LAST : ch_sel_reg - 1'b1;
      CMD_ZERO: ch_sel_next = '0;
      default:  ch_sel_next = ch_sel_reg;
    endcase
  end

  // While a command is held, new commands are dropped rather than queued.
  always_ff @(posedge clk) begin
    if (reset) begin
      ch_sel_reg  <= '0;
      cmd_reg     <= CMD_NONE;
      pending_reg <= 1'b0;
      update_reg  <= 1'b0;
    end else begin
      update_reg <= 1'b0;
      if (pending_reg) begin
        if (!adc_busy) begin
          ch_sel_reg  <= ch_sel_next;
          update_reg  <= 1'b1;
          pending_reg <= 1'b0;
          cmd_reg     <= CMD_NONE;
        end
      end else if (cmd_new != CMD_NONE) begin
        cmd_reg     <= cmd_new;
        pending_reg <= 1'b1;
      end
    end
  end

  assign ch_sel    = ch_sel_reg;
  assign ch_update = update_reg;
  assign pending   = pending_reg;

endmodule

// File: tb/tb_btn_channel_ctrl.sv
// Scoreboard bench for btn_channel_ctrl with short hold/repeat intervals.
// Stimulus pushes the expected ch_sel of each update; a negedge monitor pops on ch_update.
module tb_btn_channel_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] db_level = '0;
  logic [2:0] db_tick = '0;
  logic       adc_busy = 1'b0;
  logic [3:0] ch_sel;
  logic       ch_update;
  logic       pending;

  int n_tests = 0;
  int n_fail = 0;
  int n_updates = 0;
  logic [3:0] exp_q[$];

  localparam logic [2:0] B_UP   = 3'b001;
  localparam logic [2:0] B_DN   = 3'b010;
  localparam logic [2:0] B_HOME = 3'b100;

  btn_channel_ctrl #(
    .NCH       (13),
    .HOLD_CYC  (8),
    .REPEAT_CYC(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .db_level (db_level),
    .db_tick  (db_tick),
    .adc_busy (adc_busy),
    .ch_sel   (ch_sel),
    .ch_update(ch_update),
    .pending  (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end else begin
      $display("[TB] ok %s = %0d", name, act);
    end
  endtask

  // Monitor: every ch_update pulse must match the next queued expectation.
  always @(negedge clk) begin
    logic [3:0] e;
    if (ch_update === 1'b1) begin
      n_updates++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_update: ch_sel=%0d, required no update", ch_sel);
      end else begin
        e = exp_q.pop_front();
        check("update_ch_sel", {28'd0, ch_sel}, {28'd0, e});
      end
    end
  end

  // Tick on the first cycle, level held for n cycles in total, then released.
  task automatic press(input logic [2:0] mask, input int n);
    @(posedge clk); #1;
    db_tick  = mask;
    db_level = mask;
    for (int i = 1; i < n; i++) begin
      @(posedge clk); #1;
      db_tick = '0;
    end
    @(posedge clk); #1;
    db_tick  = '0;
    db_level = '0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    int bad;
    int base;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_ch_sel", ch_sel, 0);
    check("reset_pending", pending, 0);
    check("reset_update", ch_update, 0);

    // Latency: tick at t, pending at t+1, new channel at t+2.
    exp_q.push_back(4'd1);
    @(posedge clk); #1;
    db_tick = B_UP; db_level = B_UP;
    @(negedge clk);
    check("lat_pending_t0", pending, 0);
    @(posedge clk); #1;
    db_tick = '0; db_level = '0;
    @(negedge clk);
    check("lat_pending_t1", pending, 1);
    check("lat_ch_t1", ch_sel, 0);
    @(negedge clk);
    check("lat_update_t2", ch_update, 1);
    check("lat_pending_t2", pending, 0);
    check("lat_ch_t2", ch_sel, 1);
    cycles(2);

    // Walk up to 12, then wrap both ways.
    for (int i = 2; i <= 12; i++) begin
      exp_q.push_back(4'(i));
      press(B_UP, 1);
      cycles(3);
    end
    exp_q.push_back(4'd0);
    press(B_UP, 1);
    cycles(3);
    check("wrap_up", ch_sel, 0);
    exp_q.push_back(4'd12);
    press(B_DN, 1);
    cycles(3);
    check("wrap_down", ch_sel, 12);
    exp_q.push_back(4'd0);
    press(B_UP, 1);
    cycles(3);

    // Busy defer with a second press dropped.
    @(posedge clk); #1 adc_busy = 1'b1;
    exp_q.push_back(4'd1);
    press(B_UP, 1);
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (!(pending === 1'b1 && ch_sel === 4'd0)) bad++;
    end
    press(B_UP, 1);
    repeat (12) begin
      @(negedge clk);
      if (!(pending === 1'b1 && ch_sel === 4'd0)) bad++;
    end
    check("busy_hold_bad_cycles", bad, 0);
    @(posedge clk); #1 adc_busy = 1'b0;
    @(negedge clk);
    check("busy_first_idle_pending", pending, 1);
    check("busy_first_idle_ch", ch_sel, 0);
    @(negedge clk);
    check("busy_applied_ch", ch_sel, 1);
    check("busy_applied_pending", pending, 0);
    cycles(5);
    check("busy_net_plus1", ch_sel, 1);

    exp_q.push_back(4'd0);
    press(B_HOME, 1);
    cycles(3);
    check("home_zero", ch_sel, 0);

    // Auto-repeat: events at tick, +8, +12, +16; release at +20 suppresses the next.
    exp_q.push_back(4'd1);
    exp_q.push_back(4'd2);
    exp_q.push_back(4'd3);
    exp_q.push_back(4'd4);
    press(B_UP, 20);
    cycles(10);
    check("rpt_final_ch", ch_sel, 4);
    check("rpt_queue_left", exp_q.size(), 0);

    // Arbitration.
    press(B_UP | B_DN, 1);
    @(negedge clk);
    check("arb_ud_pending", pending, 0);
    cycles(3);
    check("arb_ud_ch", ch_sel, 4);
    exp_q.push_back(4'd5);
    press(B_UP, 1);
    cycles(3);
    exp_q.push_back(4'd0);
    press(B_UP | B_HOME, 1);
    cycles(3);
    check("arb_home_ch", ch_sel, 0);

    // Reset discards a pending command.
    for (int i = 1; i <= 7; i++) begin
      exp_q.push_back(4'(i));
      press(B_UP, 1);
      cycles(3);
    end
    check("rst_pre_ch", ch_sel, 7);
    @(posedge clk); #1 adc_busy = 1'b1;
    press(B_UP, 1);
    @(negedge clk);
    check("rst_pre_pending", pending, 1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_ch", ch_sel, 0);
    check("rst_pending", pending, 0);
    check("rst_update", ch_update, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    adc_busy = 1'b0;
    cycles(6);
    check("rst_post_ch", ch_sel, 0);
    check("rst_post_pending", pending, 0);

    // HOME held: a single update only.
    base = n_updates;
    exp_q.push_back(4'd0);
    press(B_HOME, 30);
    cycles(5);
    check("home_hold_updates", n_updates - base, 1);
    check("final_queue_left", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
